cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, entries buffered per source (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port flush  input  1  mispredict flush, synchronous.
REQ-005 SHALL have ports alu_ready/alu_res/alu_id  input  1/XLEN/ROB_SIZE_WIDTH  ALU result push.
REQ-006 SHALL have ports mem_ready/mem_res/mem_id  input  1/XLEN/ROB_SIZE_WIDTH  load result push.
REQ-007 SHALL have ports cdb_alu_stall/cdb_mem_stall  output  1 each  per-source backpressure.
REQ-008 SHALL have ports cdb_ready/cdb_val/cdb_id/cdb_src  output reg  1/XLEN/ROB_SIZE_WIDTH/1  broadcast to RS, ROB and LSB.

Function
REQ-009 SHALL keep one FIFO of {res, id} per source, depth FIFO_DEPTH, with head, tail and count registers.
REQ-010 SHALL push a source's entry at a rising edge when its ready is high, flush is low and its FIFO is not full.
REQ-011 SHALL drop a push offered while full; no error is flagged. Producers are required to honour stall.
REQ-012 SHALL drive cdb_x_stall combinationally high iff count_x == FIFO_DEPTH, even if a pop occurs in the same cycle.
REQ-013 SHALL pick at most one FIFO head per cycle: the only non-empty source, or the round-robin winner when both are non-empty.
REQ-014 SHALL round-robin by granting the source opposite last_grant; last_grant updates on every grant, including uncontested ones.
REQ-015 SHALL register the grant: cdb_ready=1, cdb_val=head res, cdb_id=head id, cdb_src (0=ALU, 1=MEM) at the edge, and pop that head at the same edge.
REQ-016 SHALL clear cdb_ready at the next edge when no source is non-empty. cdb_val, cdb_id and cdb_src then hold their last values.
REQ-017 SHALL have a latency of exactly one edge: an entry pushed at edge k into an empty, uncontested FIFO appears on cdb outputs after edge k+1.
REQ-018 SHALL support a simultaneous push and pop on one FIFO: count is unchanged and pointers wrap modulo FIFO_DEPTH.
REQ-019 SHALL have no output backpressure: a granted entry is broadcast for exactly one cycle.
REQ-020 SHALL, on flush, empty both FIFOs and zero cdb_ready at that edge; same-cycle pushes are discarded and last_grant is unchanged.
REQ-021 SHALL apply flush even when stall outputs are high.

Reset
REQ-022 SHALL on rst asynchronously clear cdb_ready, cdb_val, cdb_id, cdb_src, all pointers and counts, and set last_grant=MEM, so ALU wins the first contest.
REQ-023 SHALL hold reset state while rst is high and ignore pushes and flush during that time.
REQ-024 SHALL discard all in-flight entries if rst is asserted mid-operation; none reappear after release.

Configuration
REQ-025 SHALL, with CDB_ARBITER_FIXED_PRIO_EN defined, grant MEM over ALU whenever both are non-empty and leave last_grant unused.
REQ-026 SHALL, without CDB_ARBITER_FIXED_PRIO_EN, use the round-robin of REQ-014.

Structure
REQ-027 SHALL take CDB_SRC_ALU=1'b0 and CDB_SRC_MEM=1'b1 from global_params.v, alongside XLEN and ROB_SIZE_WIDTH.
REQ-028 SHALL instantiate one sub-module, cdb_fifo, once per source; it holds storage, pointers, count, full and empty.
REQ-029 SHALL keep arbitration, the output register and last_grant in cdb_arbiter.

Verification
REQ-030 SHALL verify: after reset, alu push {res=0x11, id=3} at edge 1 -> cdb_ready=1, val=0x11, id=3, src=0 after edge 2, cdb_ready=0 after edge 3.
REQ-031 SHALL verify: ALU and MEM push together every cycle for 4 cycles (ids 1..4 and 9..12) -> broadcast order ALU1, MEM9, ALU2, MEM10…; stalls assert when count=2, with no loss from compliant producers.
REQ-032 SHALL verify: MEM pushes 3 times with alu idle, ignoring stall -> third push dropped, exactly 2 broadcasts, cdb_mem_stall high while count=2.
REQ-033 SHALL verify: flush while both FIFOs hold 2 entries plus same-cycle pushes -> cdb_ready=0 next cycle, no later broadcasts, stalls low.
REQ-034 SHALL verify: rst pulsed mid-burst, asynchronously between edges -> outputs zero immediately; after release, the first contest grants ALU.
REQ-035 SHALL verify: with CDB_ARBITER_FIXED_PRIO_EN defined and both sources pushing for 3 cycles -> all MEM entries broadcast before any ALU entry.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared parameters and types for the common data bus (CDB) arbiter.
// Holds the global datapath widths and the source encoding.
package cdb_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int ROB_SIZE_WIDTH = 4;

  // Source tag carried on cdb_src.
  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_MEM = 1'b1
  } cdb_src_e;

  // One buffered result waiting for the bus.
  typedef struct packed {
    logic [XLEN-1:0]           res;
    logic [ROB_SIZE_WIDTH-1:0] id;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO for the CDB arbiter.
// Pushes are dropped when full, even if a pop happens in the same cycle.
// Flush empties the FIFO and discards any same-cycle push.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t din,
  output cdb_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_entry_t      storage [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign head    = storage[head_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)  head_ptr <= head_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count gates visibility, so stale
    // contents are never observed and the array can map to plain RAM/flops.
    if (do_push) storage[tail_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: buffers ALU and load results and broadcasts one per cycle.
// Default build arbitrates round-robin between the two sources.
// Define CDB_ARBITER_FIXED_PRIO_EN to give MEM fixed priority over ALU.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alu_ready,
  input  logic [XLEN-1:0]           alu_res,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
  input  logic                      mem_ready,
  input  logic [XLEN-1:0]           mem_res,
  input  logic [ROB_SIZE_WIDTH-1:0] mem_id,
  output logic                      cdb_alu_stall,
  output logic                      cdb_mem_stall,
  output logic                      cdb_ready,
  output logic [XLEN-1:0]           cdb_val,
  output logic [ROB_SIZE_WIDTH-1:0] cdb_id,
  output logic                      cdb_src
);

  cdb_entry_t alu_in, mem_in;
  cdb_entry_t alu_head, mem_head, win_head;
  logic       alu_full, alu_empty, mem_full, mem_empty;
  logic       alu_pop, mem_pop;
  logic       grant_valid;
  cdb_src_e   grant_src;

  assign alu_in = '{res: alu_res, id: alu_id};
  assign mem_in = '{res: mem_res, id: mem_id};

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (alu_ready),
    .pop   (alu_pop),
    .din   (alu_in),
    .head  (alu_head),
    .full  (alu_full),
    .empty (alu_empty)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (mem_ready),
    .pop   (mem_pop),
    .din   (mem_in),
    .head  (mem_head),
    .full  (mem_full),
    .empty (mem_empty)
  );

  // Stall reflects the current occupancy only; a same-cycle pop does not lower it.
  assign cdb_alu_stall = alu_full;
  assign cdb_mem_stall = mem_full;

`ifndef CDB_ARBITER_FIXED_PRIO_EN
  cdb_src_e last_grant;

  // Remember the last winner so the next contest goes the other way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        last_grant <= CDB_SRC_MEM;
    else if (!flush && grant_valid) last_grant <= grant_src;
  end
`endif

  // Choose which FIFO head goes on the bus this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    grant_valid = !alu_empty || !mem_empty;
    grant_src   = CDB_SRC_ALU;
    if (!alu_empty && !mem_empty) begin
`ifdef CDB_ARBITER_FIXED_PRIO_EN
      grant_src = CDB_SRC_MEM;
`else
      grant_src = (last_grant == CDB_SRC_ALU) ? CDB_SRC_MEM : CDB_SRC_ALU;
`endif
    end else if (!mem_empty) begin
      grant_src = CDB_SRC_MEM;
    end
  end

  assign alu_pop  = grant_valid && (grant_src == CDB_SRC_ALU);
  assign mem_pop  = grant_valid && (grant_src == CDB_SRC_MEM);
  assign win_head = (grant_src == CDB_SRC_MEM) ? mem_head : alu_head;

  // Registered broadcast; payload holds its last value when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_ready <= 1'b0;
      cdb_val   <= '0;
      cdb_id    <= '0;
      cdb_src   <= 1'b0;
    end else if (flush) begin
      cdb_ready <= 1'b0;
    end else if (grant_valid) begin
      cdb_ready <= 1'b1;
      cdb_val   <= win_head.res;
      cdb_id    <= win_head.id;
      cdb_src   <= grant_src;
    end else begin
      cdb_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (FIFO_DEPTH = 2).
// Contest-order scenarios depend on CDB_ARBITER_FIXED_PRIO_EN.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      alu_ready;
  logic [XLEN-1:0]           alu_res;
  logic [ROB_SIZE_WIDTH-1:0] alu_id;
  logic                      mem_ready;
  logic [XLEN-1:0]           mem_res;
  logic [ROB_SIZE_WIDTH-1:0] mem_id;
  logic                      cdb_alu_stall;
  logic                      cdb_mem_stall;
  logic                      cdb_ready;
  logic [XLEN-1:0]           cdb_val;
  logic [ROB_SIZE_WIDTH-1:0] cdb_id;
  logic                      cdb_src;

  int n_assert = 0;
  int n_fail   = 0;

  cdb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .alu_ready     (alu_ready),
    .alu_res       (alu_res),
    .alu_id        (alu_id),
    .mem_ready     (mem_ready),
    .mem_res       (mem_res),
    .mem_id        (mem_id),
    .cdb_alu_stall (cdb_alu_stall),
    .cdb_mem_stall (cdb_mem_stall),
    .cdb_ready     (cdb_ready),
    .cdb_val       (cdb_val),
    .cdb_id        (cdb_id),
    .cdb_src       (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic r, input logic [XLEN-1:0] v,
                            input logic [ROB_SIZE_WIDTH-1:0] i, input logic s);
    chk($sformatf("%s.ready", tag), XLEN'(cdb_ready), XLEN'(r));
    chk($sformatf("%s.val", tag), cdb_val, v);
    chk($sformatf("%s.id", tag), XLEN'(cdb_id), XLEN'(i));
    chk($sformatf("%s.src", tag), XLEN'(cdb_src), XLEN'(s));
  endtask

  task automatic expect_stall(input string tag, input logic a, input logic m);
    chk($sformatf("%s.alu_stall", tag), XLEN'(cdb_alu_stall), XLEN'(a));
    chk($sformatf("%s.mem_stall", tag), XLEN'(cdb_mem_stall), XLEN'(m));
  endtask

  task automatic set_alu(input logic [XLEN-1:0] r, input logic [ROB_SIZE_WIDTH-1:0] i);
    alu_ready = 1'b1;
    alu_res   = r;
    alu_id    = i;
  endtask

  task automatic set_mem(input logic [XLEN-1:0] r, input logic [ROB_SIZE_WIDTH-1:0] i);
    mem_ready = 1'b1;
    mem_res   = r;
    mem_id    = i;
  endtask

  // Advance one rising edge, then sample 1 time unit later and idle the inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    alu_ready = 1'b0;
    alu_res   = '0;
    alu_id    = '0;
    mem_ready = 1'b0;
    mem_res   = '0;
    mem_id    = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, and pushes/flush ignored while reset is held.
    expect_out("rst", 1'b0, 32'h0, 4'd0, 1'b0);
    expect_stall("rst", 1'b0, 1'b0);
    set_alu(32'h77, 4'd7); set_mem(32'h88, 4'd8); flush = 1'b1;
    tick();
    expect_out("rst_push", 1'b0, 32'h0, 4'd0, 1'b0);
    expect_stall("rst_push", 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("rst_rel", 1'b0, 32'h0, 4'd0, 1'b0);
    tick();
    expect_out("rst_rel2", 1'b0, 32'h0, 4'd0, 1'b0);

    // Single ALU push: one-edge latency, one-cycle broadcast, payload holds.
    set_alu(32'h11, 4'd3);
    tick(); expect_out("single_e1", 1'b0, 32'h0, 4'd0, 1'b0);
    tick(); expect_out("single_e2", 1'b1, 32'h11, 4'd3, 1'b0);
    tick(); expect_out("single_e3", 1'b0, 32'h11, 4'd3, 1'b0);

`ifndef CDB_ARBITER_FIXED_PRIO_EN
    // Both sources pushing with compliant producers: strict alternation.
    do_reset();
    set_alu(32'h0A01, 4'd1); set_mem(32'h0B09, 4'd9);
    tick(); expect_out("rr_e1", 1'b0, 32'h0, 4'd0, 1'b0);     expect_stall("rr_e1", 1'b0, 1'b0);
    set_alu(32'h0A02, 4'd2); set_mem(32'h0B0A, 4'd10);
    tick(); expect_out("rr_e2", 1'b1, 32'h0A01, 4'd1, 1'b0);  expect_stall("rr_e2", 1'b0, 1'b1);
    set_alu(32'h0A03, 4'd3);
    tick(); expect_out("rr_e3", 1'b1, 32'h0B09, 4'd9, 1'b1);  expect_stall("rr_e3", 1'b1, 1'b0);
    set_mem(32'h0B0B, 4'd11);
    tick(); expect_out("rr_e4", 1'b1, 32'h0A02, 4'd2, 1'b0);  expect_stall("rr_e4", 1'b0, 1'b1);
    set_alu(32'h0A04, 4'd4);
    tick(); expect_out("rr_e5", 1'b1, 32'h0B0A, 4'd10, 1'b1); expect_stall("rr_e5", 1'b1, 1'b0);
    set_mem(32'h0B0C, 4'd12);
    tick(); expect_out("rr_e6", 1'b1, 32'h0A03, 4'd3, 1'b0);  expect_stall("rr_e6", 1'b0, 1'b1);
    tick(); expect_out("rr_e7", 1'b1, 32'h0B0B, 4'd11, 1'b1); expect_stall("rr_e7", 1'b0, 1'b0);
    tick(); expect_out("rr_e8", 1'b1, 32'h0A04, 4'd4, 1'b0);
    tick(); expect_out("rr_e9", 1'b1, 32'h0B0C, 4'd12, 1'b1);
    tick(); expect_out("rr_e10", 1'b0, 32'h0B0C, 4'd12, 1'b1);

    // MEM ignores stall: the push offered while full is dropped even with a same-cycle pop.
    set_alu(32'h0A05, 4'd5); set_mem(32'h0B01, 4'd1);
    tick(); expect_out("drop_e1", 1'b0, 32'h0B0C, 4'd12, 1'b1);
    set_mem(32'h0B02, 4'd2);
    tick(); expect_out("drop_e2", 1'b1, 32'h0A05, 4'd5, 1'b0); expect_stall("drop_e2", 1'b0, 1'b1);
    set_mem(32'h0B03, 4'd3);
    tick(); expect_out("drop_e3", 1'b1, 32'h0B01, 4'd1, 1'b1); expect_stall("drop_e3", 1'b0, 1'b0);
    tick(); expect_out("drop_e4", 1'b1, 32'h0B02, 4'd2, 1'b1); expect_stall("drop_e4", 1'b0, 1'b0);
    tick(); expect_out("drop_e5", 1'b0, 32'h0B02, 4'd2, 1'b1);
    tick(); expect_out("drop_e6", 1'b0, 32'h0B02, 4'd2, 1'b1);

    // Flush with MEM full and same-cycle pushes; last_grant survives the flush.
    set_alu(32'h0A06, 4'd6); set_mem(32'h0B06, 4'd6);
    tick(); expect_out("flush_e1", 1'b0, 32'h0B02, 4'd2, 1'b1);
    set_alu(32'h0A07, 4'd7); set_mem(32'h0B07, 4'd7);
    tick(); expect_out("flush_e2", 1'b1, 32'h0A06, 4'd6, 1'b0); expect_stall("flush_e2", 1'b0, 1'b1);
    flush = 1'b1; set_alu(32'h0A08, 4'd8); set_mem(32'h0B08, 4'd8);
    tick(); expect_out("flush_e3", 1'b0, 32'h0A06, 4'd6, 1'b0); expect_stall("flush_e3", 1'b0, 1'b0);
    tick(); expect_out("flush_e4", 1'b0, 32'h0A06, 4'd6, 1'b0);
    tick(); expect_out("flush_e5", 1'b0, 32'h0A06, 4'd6, 1'b0);
    set_alu(32'h0A09, 4'd9); set_mem(32'h0B05, 4'd5);
    tick(); expect_out("flush_e6", 1'b0, 32'h0A06, 4'd6, 1'b0);
    tick(); expect_out("flush_e7", 1'b1, 32'h0B05, 4'd5, 1'b1);
    tick(); expect_out("flush_e8", 1'b1, 32'h0A09, 4'd9, 1'b0);
    tick(); expect_out("flush_e9", 1'b0, 32'h0A09, 4'd9, 1'b0);

    // Asynchronous reset mid-burst, with last_grant = ALU at the time of reset.
    set_alu(32'h0A0A, 4'd10); set_mem(32'h0B0D, 4'd13);
    tick(); expect_out("arst_e1", 1'b0, 32'h0A09, 4'd9, 1'b0);
    set_alu(32'h0A0B, 4'd11); set_mem(32'h0B0E, 4'd14);
    tick(); expect_out("arst_e2", 1'b1, 32'h0B0D, 4'd13, 1'b1);
    tick(); expect_out("arst_e3", 1'b1, 32'h0A0A, 4'd10, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_out("arst_now", 1'b0, 32'h0, 4'd0, 1'b0);
    expect_stall("arst_now", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick(); expect_out("arst_rel", 1'b0, 32'h0, 4'd0, 1'b0);
    tick(); expect_out("arst_rel2", 1'b0, 32'h0, 4'd0, 1'b0);
    set_alu(32'h0A0C, 4'd12); set_mem(32'h0B0F, 4'd15);
    tick(); expect_out("arst_e4", 1'b0, 32'h0, 4'd0, 1'b0);
    tick(); expect_out("arst_e5", 1'b1, 32'h0A0C, 4'd12, 1'b0);
    tick(); expect_out("arst_e6", 1'b1, 32'h0B0F, 4'd15, 1'b1);
    tick(); expect_out("arst_e7", 1'b0, 32'h0B0F, 4'd15, 1'b1);
`else
    // Fixed priority: every MEM entry is broadcast before any ALU entry.
    do_reset();
    set_alu(32'h0A01, 4'd1); set_mem(32'h0B01, 4'd1);
    tick(); expect_out("fp_e1", 1'b0, 32'h0, 4'd0, 1'b0);
    set_alu(32'h0A02, 4'd2); set_mem(32'h0B02, 4'd2);
    tick(); expect_out("fp_e2", 1'b1, 32'h0B01, 4'd1, 1'b1); expect_stall("fp_e2", 1'b1, 1'b0);
    set_mem(32'h0B03, 4'd3);
    tick(); expect_out("fp_e3", 1'b1, 32'h0B02, 4'd2, 1'b1); expect_stall("fp_e3", 1'b1, 1'b0);
    tick(); expect_out("fp_e4", 1'b1, 32'h0B03, 4'd3, 1'b1); expect_stall("fp_e4", 1'b1, 1'b0);
    tick(); expect_out("fp_e5", 1'b1, 32'h0A01, 4'd1, 1'b0); expect_stall("fp_e5", 1'b0, 1'b0);
    set_alu(32'h0A03, 4'd3);
    tick(); expect_out("fp_e6", 1'b1, 32'h0A02, 4'd2, 1'b0);
    tick(); expect_out("fp_e7", 1'b1, 32'h0A03, 4'd3, 1'b0);
    tick(); expect_out("fp_e8", 1'b0, 32'h0A03, 4'd3, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
